jtbubl_snd_comm: RTL and testbench



---
 rtl/jtbubl_snd_comm.sv | 145 ++++++++++++++
 tb/tb_jtbubl_snd_comm.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtbubl_snd_comm.sv
//------------------------------------------------------------------------------
// jtbubl_snd_comm
// Main-CPU-side sound communication block: command latch with strobe, reply
// capture with pending/overrun flags and interrupt, and a held sound-CPU reset.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jtbubl_snd_comm #(
  parameter int SRST_HOLD = 16,
  parameter int CW        = 5
) (
  input  logic       rstn,
  input  logic       clk,
  input  logic       main_cs,
  input  logic [1:0] main_addr,
  input  logic       main_wr_n,
  input  logic       main_rd_n,
  input  logic [7:0] main_dout,
  output logic [7:0] main_din,
  output logic       main_int_n,
  output logic [7:0] snd_latch,
  output logic       snd_stb,
  output logic       snd_rstn,
  input  logic [7:0] snd_reply,
  input  logic       snd_reply_stb
);

  localparam logic [0:0]    ST_HOLD  = 1'b0;
  localparam logic [0:0]    ST_RUN   = 1'b1;
  localparam logic [CW-1:0] HOLD_VAL = CW'(SRST_HOLD);

  logic          wr_acc, rd_acc;
  logic          wr_acc_q, rd_acc_q;
  logic          wr_first, rd_first;
  logic          clr_pend, clr_ovr, reply_take;
  logic [7:0]    reply;
  logic          reply_pend, overrun;
  logic          int_en, srst_bit;
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          unused_ok;

  assign wr_acc     = main_cs & ~main_wr_n;
  assign rd_acc     = main_cs & ~main_rd_n;
  // Side effects only on the first cycle of a bus access
  assign wr_first   = wr_acc & ~wr_acc_q;
  assign rd_first   = rd_acc & ~rd_acc_q;
  assign clr_pend   = rd_first && (main_addr == 2'd0);
  assign clr_ovr    = rd_first && (main_addr == 2'd1);
  // Replies are meaningless while the sound CPU is held in reset
  assign reply_take = snd_reply_stb & snd_rstn;
  assign snd_rstn   = (state == ST_RUN);
  // Upper control bits are reserved
  assign unused_ok  = &{1'b0, main_dout[7:2]};

  // Delayed copies of the access strobes for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_acc_q <= 1'b0;
      rd_acc_q <= 1'b0;
    end else begin
      wr_acc_q <= wr_acc;
      rd_acc_q <= rd_acc;
    end
  end

  // Register writes: command latch with one-cycle strobe, control bits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snd_latch <= 8'h00;
      snd_stb   <= 1'b0;
      srst_bit  <= 1'b0;
      int_en    <= 1'b0;
    end else begin
      snd_stb <= wr_first && (main_addr == 2'd0);
      if (wr_first) begin
        case (main_addr)
          2'd0: snd_latch <= main_dout;
          2'd1: begin
            srst_bit <= main_dout[0];
            int_en   <= main_dout[1];
          end
          default: ;
        endcase
      end
    end
  end

  // Reply capture; a new strobe beats a same-cycle clear of either flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reply      <= 8'h00;
      reply_pend <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (reply_take) reply <= snd_reply;
      reply_pend <= reply_take | (reply_pend & ~clr_pend);
      overrun    <= (overrun & ~clr_ovr) | (reply_take & reply_pend & ~clr_pend);
    end
  end

  // Level interrupt, one cycle behind the flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) main_int_n <= 1'b1;
    else       main_int_n <= ~(reply_pend & int_en);
  end

  // Sound reset: hold low for the full count after every request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_HOLD;
      cnt   <= HOLD_VAL;
    end else begin
      case (state)
        ST_HOLD: begin
          if (srst_bit)          cnt   <= HOLD_VAL;
          else if (cnt == '0)    state <= ST_RUN;
          else                   cnt   <= cnt - 1'b1;
        end
        default: begin
          if (srst_bit) begin
            state <= ST_HOLD;
            cnt   <= HOLD_VAL;
          end
        end
      endcase
    end
  end

  // Read data mux, idle value when no read strobe
  always_comb begin
    main_din = 8'hFF;
    if (rd_acc) begin
      case (main_addr)
        2'd0:    main_din = reply;
        2'd1:    main_din = {6'b0, overrun, reply_pend};
        default: main_din = 8'hFF;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtbubl_snd_comm.sv
//------------------------------------------------------------------------------
// tb_jtbubl_snd_comm
// Table vectors, hand sequences and random traffic against a behavioural model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_jtbubl_snd_comm;

  localparam int SRST_HOLD = 16;
  localparam int REL_LEN   = SRST_HOLD + 1;

  logic       rstn = 1'b0, clk = 1'b0;
  logic       main_cs = 1'b0, main_wr_n = 1'b1, main_rd_n = 1'b1;
  logic [1:0] main_addr = 2'd0;
  logic [7:0] main_dout = 8'h00, snd_reply = 8'h00;
  logic       snd_reply_stb = 1'b0;
  logic [7:0] main_din, snd_latch;
  logic       main_int_n, snd_stb, snd_rstn;

  jtbubl_snd_comm #(.SRST_HOLD(SRST_HOLD), .CW(5)) dut (
    .rstn(rstn), .clk(clk), .main_cs(main_cs), .main_addr(main_addr),
    .main_wr_n(main_wr_n), .main_rd_n(main_rd_n), .main_dout(main_dout),
    .main_din(main_din), .main_int_n(main_int_n), .snd_latch(snd_latch),
    .snd_stb(snd_stb), .snd_rstn(snd_rstn), .snd_reply(snd_reply),
    .snd_reply_stb(snd_reply_stb)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Behavioural model: register file plus "edges seen with reset request clear"
  logic [7:0] m_latch, m_reply;
  logic       m_stb, m_pend, m_ovr, m_inten, m_srst, m_intn, m_pwr, m_prd;
  int         m_run;

  function automatic void model_reset();
    m_latch = 8'h00; m_reply = 8'h00; m_stb = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
    m_inten = 1'b0; m_srst = 1'b0; m_intn = 1'b1; m_pwr = 1'b0; m_prd = 1'b0;
    m_run = 0;
  endfunction

  function automatic logic m_rstn();
    return m_run >= REL_LEN;
  endfunction

  function automatic logic [7:0] m_din();
    if (!(main_cs && !main_rd_n)) return 8'hFF;
    if (main_addr == 2'd0) return m_reply;
    if (main_addr == 2'd1) return {6'b0, m_ovr, m_pend};
    return 8'hFF;
  endfunction

  function automatic void model_edge();
    logic wr, rd, fw, fr, take, cp, co;
    wr   = main_cs && !main_wr_n;
    rd   = main_cs && !main_rd_n;
    fw   = wr && !m_pwr;
    fr   = rd && !m_prd;
    take = snd_reply_stb && m_rstn();
    cp   = fr && main_addr == 2'd0;
    co   = fr && main_addr == 2'd1;
    m_intn = !(m_pend && m_inten);
    m_run  = m_srst ? 0 : ((m_run < REL_LEN) ? m_run + 1 : REL_LEN);
    m_stb  = fw && main_addr == 2'd0;
    if (fw && main_addr == 2'd0) m_latch = main_dout;
    if (fw && main_addr == 2'd1) begin
      m_srst  = main_dout[0];
      m_inten = main_dout[1];
    end
    m_ovr  = (co ? 1'b0 : m_ovr) | (take && m_pend && !cp);
    m_pend = take ? 1'b1 : (cp ? 1'b0 : m_pend);
    if (take) m_reply = snd_reply;
    m_pwr = wr;
    m_prd = rd;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic cs, input logic [1:0] a, input logic wn, input logic rn,
                       input logic [7:0] d, input logic rs, input logic [7:0] rdat);
    main_cs = cs; main_addr = a; main_wr_n = wn; main_rd_n = rn; main_dout = d;
    snd_reply_stb = rs; snd_reply = rdat;
    #3;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_check();
    check("m_din",   main_din,          m_din());
    check("m_latch", snd_latch,         m_latch);
    check("m_stb",   {7'b0, snd_stb},    {7'b0, m_stb});
    check("m_int_n", {7'b0, main_int_n}, {7'b0, m_intn});
    check("m_rstn",  {7'b0, snd_rstn},   {7'b0, m_rstn()});
  endtask

  task automatic step(input logic cs, input logic [1:0] a, input logic wn, input logic rn,
                      input logic [7:0] d, input logic rs, input logic [7:0] rdat);
    apply(cs, a, wn, rn, d, rs, rdat);
    model_check();
    advance();
  endtask

  typedef struct {
    logic cs; logic [1:0] a; logic wn; logic rn; logic [7:0] d; logic rs; logic [7:0] rdat;
    logic [7:0] din; logic [7:0] latch; logic stb; logic intn;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input logic cs, input logic [1:0] a, input logic wn, input logic rn,
                      input logic [7:0] d, input logic rs, input logic [7:0] rdat,
                      input logic [7:0] din, input logic [7:0] latch, input logic stb,
                      input logic intn);
    vec_t v;
    v.cs = cs; v.a = a; v.wn = wn; v.rn = rn; v.d = d; v.rs = rs; v.rdat = rdat;
    v.din = din; v.latch = latch; v.stb = stb; v.intn = intn;
    tbl.push_back(v);
  endtask

  initial begin
    int lows;
    logic cs, wn, rn, rs;
    logic [1:0] a;
    logic [7:0] d, rdat;

    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Release: sound reset held for SRST_HOLD+1 cycles
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      apply(1'b0, 2'd0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
      if (i == 0) check("reset_int_n", {7'b0, main_int_n}, 8'h01);
      if (i == 0) check("reset_latch", snd_latch, 8'h00);
      if (snd_rstn === 1'b0 && lows == i) lows++;
      advance();
    end
    check("release_low_cycles", lows[7:0], 8'd17);
    step(1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    check("reset_status", main_din, 8'h00);
    step(1'b0, 2'd0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);

    //    cs a  wn rn d      rs rdat   | din    latch  stb int_n
    addv(1, 0, 0, 1, 8'hA5, 0, 8'h00, 8'hFF, 8'h00, 0, 1);
    addv(1, 0, 0, 1, 8'hA5, 0, 8'h00, 8'hFF, 8'hA5, 1, 1);
    addv(1, 0, 0, 1, 8'hA5, 0, 8'h00, 8'hFF, 8'hA5, 0, 1);
    addv(1, 0, 0, 1, 8'hA5, 0, 8'h00, 8'hFF, 8'hA5, 0, 1);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 1);
    addv(1, 1, 0, 1, 8'h02, 0, 8'h00, 8'hFF, 8'hA5, 0, 1);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 1);
    addv(0, 0, 1, 1, 8'h00, 1, 8'h3C, 8'hFF, 8'hA5, 0, 1);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 1);
    addv(1, 1, 1, 0, 8'h00, 0, 8'h00, 8'h01, 8'hA5, 0, 0);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(1, 0, 1, 0, 8'h00, 0, 8'h00, 8'h3C, 8'hA5, 0, 0);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 1);
    addv(1, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'hA5, 0, 1);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 1);
    addv(0, 0, 1, 1, 8'h00, 1, 8'h11, 8'hFF, 8'hA5, 0, 1);
    addv(0, 0, 1, 1, 8'h00, 1, 8'h22, 8'hFF, 8'hA5, 0, 1);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(1, 1, 1, 0, 8'h00, 0, 8'h00, 8'h03, 8'hA5, 0, 0);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(1, 0, 1, 0, 8'h00, 0, 8'h00, 8'h22, 8'hA5, 0, 0);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(1, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'hA5, 0, 1);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 1);
    addv(0, 0, 1, 1, 8'h00, 1, 8'h55, 8'hFF, 8'hA5, 0, 1);
    addv(1, 0, 1, 0, 8'h00, 1, 8'h66, 8'h55, 8'hA5, 0, 1);
    addv(1, 0, 1, 0, 8'h00, 0, 8'h00, 8'h66, 8'hA5, 0, 0);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(1, 1, 1, 0, 8'h00, 0, 8'h00, 8'h01, 8'hA5, 0, 0);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(1, 1, 1, 0, 8'h00, 1, 8'h77, 8'h01, 8'hA5, 0, 0);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(1, 1, 1, 0, 8'h00, 0, 8'h00, 8'h03, 8'hA5, 0, 0);
    addv(1, 2, 1, 0, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(1, 2, 0, 1, 8'h5A, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(1, 0, 0, 1, 8'h3C, 0, 8'h00, 8'hFF, 8'hA5, 0, 0);
    addv(0, 0, 1, 1, 8'h00, 0, 8'h00, 8'hFF, 8'h3C, 1, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].cs, tbl[i].a, tbl[i].wn, tbl[i].rn, tbl[i].d, tbl[i].rs, tbl[i].rdat);
      check($sformatf("vec%0d_din", i),   main_din,          tbl[i].din);
      check($sformatf("vec%0d_latch", i), snd_latch,         tbl[i].latch);
      check($sformatf("vec%0d_stb", i),   {7'b0, snd_stb},    {7'b0, tbl[i].stb});
      check($sformatf("vec%0d_int_n", i), {7'b0, main_int_n}, {7'b0, tbl[i].intn});
      check($sformatf("vec%0d_rstn", i),  {7'b0, snd_rstn},   8'h01);
      advance();
    end

    // Asynchronous reset while a command strobe is being output
    step(1'b1, 2'd0, 1'b0, 1'b1, 8'h99, 1'b0, 8'h00);
    check("pre_rst_stb", {7'b0, snd_stb}, 8'h01);
    #1 rstn = 1'b0;
    #1;
    check("async_stb",   {7'b0, snd_stb},    8'h00);
    check("async_latch", snd_latch,          8'h00);
    check("async_rstn",  {7'b0, snd_rstn},   8'h00);
    check("async_int_n", {7'b0, main_int_n}, 8'h01);
    model_reset();
    apply(1'b0, 2'd0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 2'd0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);

    // Register-requested sound reset with replies strobed during the low phase
    for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00);
    apply(1'b0, 2'd0, 1'b1, 1'b1, 8'h00, 1'b1, 8'hEE);
    model_check();
    check("srst_low", {7'b0, snd_rstn}, 8'h00);
    advance();
    step(1'b1, 2'd1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    lows = 0;
    for (int i = 0; i < 25; i++) begin
      apply(1'b0, 2'd0, 1'b1, 1'b1, 8'h00, (i < 10), 8'hE0 + 8'(i));
      model_check();
      if (snd_rstn === 1'b0 && lows == i) lows++;
      advance();
    end
    check("srst_low_cycles", lows[7:0], 8'd17);
    step(1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    step(1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    apply(1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    check("no_capture_in_hold", main_din, 8'h00);
    advance();

    // Random traffic against the model
    cs = 0; a = 0; wn = 1; rn = 1; d = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        int k;
        k = $urandom_range(0, 9);
        a = 2'($urandom_range(0, 3));
        d = 8'($urandom);
        cs = (k >= 4); wn = 1'b1; rn = 1'b1;
        if (k >= 4 && k <= 6) rn = 1'b0;
        if (k >= 7) begin
          wn = 1'b0;
          if (a == 2'd1) d = {6'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0)};
        end
      end
      rs = ($urandom_range(0, 4) == 0);
      rdat = 8'($urandom);
      step(cs, a, wn, rn, d, rs, rdat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
